// File: rtl/clk_div_monitor_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_monitor_pkg : state encoding and compare helper for clock monitors
// Rev 1.0
// ============================================================================
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } mon_state_e;

  // Lower edge of a tolerance window, clamped at zero.
  function automatic int lower_bound(input int nominal, input int tol);
    return (nominal > tol) ? (nominal - tol) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_monitor_edge_sync.sv
`default_nettype none
// ============================================================================
// clk_div_monitor_edge_sync : 2-flop synchroniser plus delay flop, rise detect
// Rev 1.0
// ============================================================================
module clk_div_monitor_edge_sync (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// clk_div_monitor : measures a divided clock over NPER periods, flags match/lock
// Rev 1.0
// ============================================================================
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NPER    = 8,
  parameter int EXP_DIV = 5,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             tclk_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             match,
  output logic             timeout,
  output logic             locked
);

  localparam int               NOMINAL   = EXP_DIV * NPER;
  localparam logic [CNT_W:0]   MATCH_LO  = (CNT_W+1)'(lower_bound(NOMINAL, TOL));
  localparam logic [CNT_W:0]   MATCH_HI  = (CNT_W+1)'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(NPER - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             w_lvl, w_rise;
  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] edge_q, edge_d, period_q, period_d, high_q, high_d, idle_q, idle_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic             done_q, done_d, match_q, match_d, tmo_q, tmo_d;
  logic             locked_q, locked_d, prev_ok_q, prev_ok_d;
  logic [CNT_W-1:0] w_period_inc, w_high_inc;
  logic             w_fin_match, w_final_rise, w_tmo_hit;

  clk_div_monitor_edge_sync u_sync (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .async_i (tclk_in),
    .lvl_o   (w_lvl),
    .rise_o  (w_rise)
  );

  assign w_period_inc = sat_inc(period_q);
  assign w_high_inc   = w_lvl ? sat_inc(high_q) : high_q;
  assign w_fin_match  = ({1'b0, w_period_inc} >= MATCH_LO) && ({1'b0, w_period_inc} <= MATCH_HI);
  assign w_final_rise = (state_q == ST_MEAS) && w_rise && (edge_q == EDGE_LAST);
  // A rise in the terminal-count cycle takes precedence over the timeout.
  assign w_tmo_hit    = ((state_q == ST_ARM) || (state_q == ST_MEAS)) && !w_rise &&
                        (idle_q == IDLE_LAST);

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    period_d  = period_q;
    high_d    = high_q;
    idle_d    = idle_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    done_d    = 1'b0;
    match_d   = match_q;
    tmo_d     = tmo_q;
    locked_d  = locked_q;
    prev_ok_d = prev_ok_q;

    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (start) begin
          state_d   = ST_ARM;
          locked_d  = 1'b0;
          prev_ok_d = 1'b0;
        end
      end
      ST_ARM: begin
        idle_d = idle_q + 1'b1;
        if (w_rise) begin
          state_d  = ST_MEAS;
          edge_d   = '0;
          period_d = '0;
          high_d   = '0;
          idle_d   = '0;
        end
      end
      ST_MEAS: begin
        period_d = w_period_inc;
        high_d   = w_high_inc;
        idle_d   = idle_q + 1'b1;
        if (w_rise) begin
          idle_d = '0;
          edge_d = edge_q + 1'b1;
          if (w_final_rise) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            pcnt_d    = w_period_inc;
            hcnt_d    = w_high_inc;
            match_d   = w_fin_match;
            tmo_d     = 1'b0;
            locked_d  = w_fin_match && prev_ok_q;
            prev_ok_d = w_fin_match;
            // The final rise doubles as the start edge of a continuous re-run.
            edge_d    = '0;
            period_d  = '0;
            high_d    = '0;
          end
        end
      end
      ST_DONE: begin
        period_d = w_period_inc;
        high_d   = w_high_inc;
        idle_d   = '0;
        state_d  = (cont && !tmo_q) ? ST_MEAS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_tmo_hit) begin
      state_d   = ST_DONE;
      done_d    = 1'b1;
      pcnt_d    = '0;
      hcnt_d    = '0;
      match_d   = 1'b0;
      tmo_d     = 1'b1;
      locked_d  = 1'b0;
      prev_ok_d = 1'b0;
      idle_d    = '0;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= ST_IDLE;
      edge_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      idle_q    <= '0;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      tmo_q     <= 1'b0;
      locked_q  <= 1'b0;
      prev_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      period_q  <= period_d;
      high_q    <= high_d;
      idle_q    <= idle_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      done_q    <= done_d;
      match_q   <= match_d;
      tmo_q     <= tmo_d;
      locked_q  <= locked_d;
      prev_ok_q <= prev_ok_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign period_cnt = pcnt_q;
  assign high_cnt   = hcnt_q;
  assign match      = match_q;
  assign timeout    = tmo_q;
  assign locked     = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// tb_clk_div_monitor : randomized and directed checks against a period-list model
// Rev 1.0
// ============================================================================
module tb_clk_div_monitor;

  localparam int CNT_W   = 16;
  localparam int NPER    = 8;
  localparam int EXP_DIV = 5;
  localparam int TOL     = 2;
  localparam int TIMEOUT = 1023;
  localparam int NOM     = EXP_DIV * NPER;

  logic             sclk    = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             tclk_in = 1'b0;
  logic             start   = 1'b0;
  logic             cont    = 1'b0;
  logic             busy, done, match, timeout, locked;
  logic [CNT_W-1:0] period_cnt, high_cnt;

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ph[$];
  int pl[$];

  clk_div_monitor #(
    .CNT_W(CNT_W), .NPER(NPER), .EXP_DIV(EXP_DIV), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .tclk_in(tclk_in), .start(start), .cont(cont),
    .busy(busy), .done(done), .period_cnt(period_cnt), .high_cnt(high_cnt),
    .match(match), .timeout(timeout), .locked(locked)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  // Sum over the NPER tclk periods of measurement r: whole periods or only the high phases.
  function automatic int chunk_sum(input int r, input bit highs_only);
    int s = 0;
    for (int i = NPER * r; i < NPER * r + NPER; i++)
      s += highs_only ? ph[i] : (ph[i] + pl[i]);
    return s;
  endfunction

  task automatic fill_fixed(input int n, input int h, input int l);
    ph.delete();
    pl.delete();
    repeat (n) begin
      ph.push_back(h);
      pl.push_back(l);
    end
  endtask

  task automatic fill_rand(input int n);
    int len;
    ph.delete();
    pl.delete();
    repeat (n) begin
      len = int'($urandom_range(7, 3));
      ph.push_back(int'($urandom_range(len - 1, 1)));
      pl.push_back(len - ph[ph.size() - 1]);
    end
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge sclk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Plays the queued periods on tclk; drops cont inside the last measurement of m.
  task automatic drive_q(input int m, input int sp_idx);
    for (int i = 0; i < ph.size(); i++) begin
      if (m > 1 && i == NPER * (m - 1) + 2) cont = 1'b0;
      for (int j = 0; j < ph[i]; j++) begin
        @(negedge sclk);
        tclk_in = 1'b1;
        if (i == sp_idx && j == 0) start = 1'b1;
      end
      for (int j = 0; j < pl[i]; j++) begin
        @(negedge sclk);
        tclk_in = 1'b0;
        start   = 1'b0;
      end
    end
  endtask

  task automatic run_meas(input string tag, input int m, input int sp_idx);
    bit got;
    bit prev_m, m_exp;
    int p, h, last_cyc, extra;
    @(negedge sclk);
    start = 1'b1;
    cont  = (m > 1);
    @(negedge sclk);
    start = 1'b0;
    repeat (2) @(negedge sclk);
    chk({tag, "_lock_clr"}, locked, 0);
    fork
      drive_q(m, sp_idx);
      begin
        prev_m   = 1'b0;
        last_cyc = 0;
        for (int r = 0; r < m; r++) begin
          wait_done(400, got);
          chk({tag, "_done_seen"}, got, 1);
          if (!got) break;
          p     = chunk_sum(r, 1'b0);
          h     = chunk_sum(r, 1'b1);
          m_exp = (p >= NOM - TOL) && (p <= NOM + TOL);
          chk({tag, "_period"}, period_cnt, p);
          chk({tag, "_high"}, high_cnt, h);
          chk({tag, "_match"}, match, m_exp);
          chk({tag, "_timeout"}, timeout, 0);
          chk({tag, "_locked"}, locked, m_exp && prev_m);
          if (r > 0) chk({tag, "_gap"}, cyc - last_cyc, p);
          last_cyc = cyc;
          prev_m   = m_exp;
        end
        @(negedge sclk);
        chk({tag, "_busy_after"}, busy, 0);
        extra = 0;
        repeat (60) begin
          @(negedge sclk);
          if (done === 1'b1) extra++;
        end
        chk({tag, "_extra_done"}, extra, 0);
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int t0, cnt, nm;

    repeat (3) @(negedge sclk);
    chk_all_zero("reset");
    s_rst_n = 1'b1;
    repeat (3) @(negedge sclk);

    fill_fixed(NPER + 1, 2, 3);
    run_meas("div5", 1, -1);

    fill_fixed(3 * NPER + 1, 2, 3);
    run_meas("div5_cont", 3, -1);

    fill_fixed(NPER + 1, 3, 3);
    run_meas("div6", 1, -1);

    // tclk stuck low, cont set: expect a timeout result and a return to IDLE.
    @(negedge sclk);
    start = 1'b1;
    cont  = 1'b1;
    t0    = cyc;
    @(negedge sclk);
    start = 1'b0;
    wait_done(1100, got);
    chk("tmo_done_seen", got, 1);
    chk("tmo_latency_ok", ((cyc - t0) >= 1020) && ((cyc - t0) <= 1028), 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_period", period_cnt, 0);
    chk("tmo_high", high_cnt, 0);
    chk("tmo_match", match, 0);
    chk("tmo_locked", locked, 0);
    @(negedge sclk);
    chk("tmo_busy_after", busy, 0);
    cont = 1'b0;
    repeat (5) @(negedge sclk);

    fill_fixed(NPER + 1, 2, 3);
    run_meas("start_ign", 1, 4);

    // Async reset in the middle of a measurement.
    fill_fixed(20, 2, 3);
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    fork
      drive_q(1, -1);
      begin
        repeat (25) @(negedge sclk);
        chk("rst_mid_busy_pre", busy, 1);
        s_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge sclk);
        s_rst_n = 1'b1;
        cnt = 0;
        repeat (100) begin
          @(negedge sclk);
          if (done === 1'b1) cnt++;
        end
        chk("rst_mid_no_done", cnt, 0);
      end
    join
    fill_fixed(NPER + 1, 2, 3);
    run_meas("after_rst", 1, -1);

    for (int t = 0; t < 6; t++) begin
      nm = int'($urandom_range(3, 1));
      fill_rand(NPER * nm + 1);
      run_meas("rand", nm, -1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
